// File: rtl/cram_pkg.sv
// Shared types and constants for the cellular-RAM responder model.
package cram_pkg;

    localparam int unsigned DATA_BITS     = 16;
    localparam int unsigned CNT_BITS      = 4;
    localparam int unsigned CNT_MAX       = (1 << CNT_BITS) - 1;
    localparam int unsigned DEF_ADDR_BITS = 8;
    localparam int unsigned DEF_READ_LAT  = 3;
    localparam int unsigned DEF_WRITE_LAT = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DRIVE = 3'd2,
        WR_WAIT  = 3'd3,
        WR_HOLD  = 3'd4
    } cram_state_e;

    typedef logic [CNT_BITS-1:0] lat_cnt_t;

    // Write payload held across the access; byte enables stay active-low as sampled
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 ub_n;
        logic                 lb_n;
    } wr_payload_t;

    // Saturating latency counter increment
    function automatic lat_cnt_t sat_inc(input lat_cnt_t c);
        return (c == lat_cnt_t'(CNT_MAX)) ? c : c + lat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/cram_array.sv
// Single-port word storage with per-byte write enables and asynchronous read.
module cram_array
    import cram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [1:0]           byte_we,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Byte-lane writes; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (byte_we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (byte_we[1]) mem[addr][15:8] <= wdata[15:8];
    end

    // Asynchronous read of the addressed word
    assign rdata_c = mem[addr];

endmodule

// File: rtl/cram_responder.sv
// Asynchronous-mode cellular RAM bus responder with configurable read/write latency.
module cram_responder
    import cram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned READ_LAT  = DEF_READ_LAT,
    parameter int unsigned WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MemAdv,
    input  logic                 MemClk,
    input  logic                 RamCS,
    input  logic                 MemOE,
    input  logic                 MemWR,
    input  logic                 RamLB,
    input  logic                 RamUB,
    input  logic [26:1]          MemAdr,
    inout  wire  [DATA_BITS-1:0] MemDB,
    output logic                 mem_wait,
    output logic                 wr_abort
);

    // Counter starts at 1 on the start edge, so reads finish when it reaches READ_LAT
    // and writes move to hold once WRITE_LAT low samples have been seen.
    localparam lat_cnt_t RD_DONE  = lat_cnt_t'(READ_LAT);
    localparam lat_cnt_t WR_DONE  = lat_cnt_t'(WRITE_LAT - 1);
    localparam bit       WR_SHORT = (WRITE_LAT <= 1);

    cram_state_e          state;
    lat_cnt_t             cnt;
    logic [ADDR_BITS-1:0] addr_q;
    wr_payload_t          wr_q;
    logic                 drive;

    logic [ADDR_BITS-1:0] bus_addr;
    logic                 cs_on;
    logic                 oe_on;
    logic                 wr_on;
    logic                 wr_end;
    logic                 addr_moved;
    logic                 commit_c;
    logic [1:0]           byte_we_c;
    logic [DATA_BITS-1:0] rdata_c;
    logic                 unused_pins;

    assign bus_addr   = MemAdr[ADDR_BITS:1];
    assign cs_on      = !RamCS;
    assign oe_on      = !MemOE;
    assign wr_on      = !MemWR;
    assign wr_end     = RamCS | MemWR;
    assign addr_moved = (bus_addr != addr_q);

    // Commit happens on the edge that sees the write strobe end while holding
    assign commit_c  = (state == WR_HOLD) && wr_end;
    assign byte_we_c = commit_c ? {!wr_q.ub_n, !wr_q.lb_n} : 2'b00;

    // Burst-mode pins and aliased upper address bits have no effect in async mode
    assign unused_pins = ^{MemAdv, MemClk, MemAdr[26:ADDR_BITS+1]};

    cram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .addr    (addr_q),
        .byte_we (byte_we_c),
        .wdata   (wr_q.data),
        .rdata_c (rdata_c)
    );

    // Bus is only driven from a register, never straight from bus inputs
    assign MemDB = drive ? rdata_c : {DATA_BITS{1'bz}};

    // Access sequencer with registered bus-drive, wait and abort outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            wr_q     <= '0;
            drive    <= 1'b0;
            mem_wait <= 1'b0;
            wr_abort <= 1'b0;
        end else begin
            wr_abort <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_on && wr_on) begin
                        state     <= WR_SHORT ? WR_HOLD : WR_WAIT;
                        mem_wait  <= !WR_SHORT;
                        drive     <= 1'b0;
                        cnt       <= lat_cnt_t'(1);
                        addr_q    <= bus_addr;
                        wr_q.data <= MemDB;
                        wr_q.ub_n <= RamUB;
                        wr_q.lb_n <= RamLB;
                    end else if (cs_on && oe_on) begin
                        state     <= RD_WAIT;
                        mem_wait  <= 1'b1;
                        drive     <= 1'b0;
                        cnt       <= lat_cnt_t'(1);
                        addr_q    <= bus_addr;
                        wr_q.ub_n <= RamUB;
                        wr_q.lb_n <= RamLB;
                    end
                end
                RD_WAIT, RD_DRIVE: begin
                    if (!cs_on) begin
                        state    <= IDLE;
                        mem_wait <= 1'b0;
                        drive    <= 1'b0;
                    end else if (wr_on) begin
                        state     <= WR_SHORT ? WR_HOLD : WR_WAIT;
                        mem_wait  <= !WR_SHORT;
                        drive     <= 1'b0;
                        cnt       <= lat_cnt_t'(1);
                        addr_q    <= bus_addr;
                        wr_q.data <= MemDB;
                        wr_q.ub_n <= RamUB;
                        wr_q.lb_n <= RamLB;
                    end else if (!oe_on) begin
                        state    <= IDLE;
                        mem_wait <= 1'b0;
                        drive    <= 1'b0;
                    end else if (addr_moved) begin
                        state    <= RD_WAIT;
                        mem_wait <= 1'b1;
                        drive    <= 1'b0;
                        cnt      <= lat_cnt_t'(1);
                        addr_q   <= bus_addr;
                    end else if (state == RD_WAIT) begin
                        if (cnt >= RD_DONE) begin
                            state    <= RD_DRIVE;
                            mem_wait <= 1'b0;
                            drive    <= 1'b1;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                WR_WAIT: begin
                    if (wr_end) begin
                        state    <= IDLE;
                        mem_wait <= 1'b0;
                        wr_abort <= 1'b1;
                    end else begin
                        wr_q.data <= MemDB;
                        if (cnt >= WR_DONE) begin
                            state    <= WR_HOLD;
                            mem_wait <= 1'b0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                WR_HOLD: begin
                    if (wr_end) begin
                        state    <= IDLE;
                        mem_wait <= 1'b0;
                    end else begin
                        wr_q.data <= MemDB;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_wait <= 1'b0;
                    drive    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cram_responder.sv
// Directed, table-driven bench for cram_responder (default parameters).
module tb_cram_responder;

    localparam int unsigned READ_LAT  = 3;
    localparam int unsigned WRITE_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemAdv;
    logic        MemClk;
    logic        RamCS;
    logic        MemOE;
    logic        MemWR;
    logic        RamLB;
    logic        RamUB;
    logic [26:1] MemAdr;
    wire  [15:0] MemDB;
    logic        mem_wait;
    logic        wr_abort;

    logic        tb_oe;
    logic [15:0] tb_dout;

    int checks   = 0;
    int failures = 0;

    assign MemDB = tb_oe ? tb_dout : 16'hzzzz;

    always #5 clk = ~clk;

    cram_responder #(
        .ADDR_BITS (8),
        .READ_LAT  (READ_LAT),
        .WRITE_LAT (WRITE_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemAdv   (MemAdv),
        .MemClk   (MemClk),
        .RamCS    (RamCS),
        .MemOE    (MemOE),
        .MemWR    (MemWR),
        .RamLB    (RamLB),
        .RamUB    (RamUB),
        .MemAdr   (MemAdr),
        .MemDB    (MemDB),
        .mem_wait (mem_wait),
        .wr_abort (wr_abort)
    );

    typedef struct {
        bit          is_rd;
        logic [25:0] addr;
        logic [15:0] data;   // write data, or expected read data
        logic        lb;
        logic        ub;
        logic        oe;
        int unsigned ncyc;
        bit          abort;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Probe the bus with a zero driver; a released bus reads back zero
    task automatic check_released(input string nm);
        tb_dout = 16'h0000;
        tb_oe   = 1'b1;
        #1;
        check(nm, MemDB, 16'h0000);
        tb_oe = 1'b0;
    endtask

    function automatic vec_t wv(input logic [25:0] a, input logic [15:0] d, input logic lb,
                                input logic ub, input logic oe, input int unsigned n, input bit ab);
        vec_t v;
        v.is_rd = 1'b0; v.addr = a; v.data = d; v.lb = lb; v.ub = ub;
        v.oe = oe; v.ncyc = n; v.abort = ab;
        return v;
    endfunction

    function automatic vec_t rv(input logic [25:0] a, input logic [15:0] exp);
        vec_t v;
        v.is_rd = 1'b1; v.addr = a; v.data = exp; v.lb = 1'b0; v.ub = 1'b0;
        v.oe = 1'b0; v.ncyc = 0; v.abort = 1'b0;
        return v;
    endfunction

    task automatic do_write(input int idx, input vec_t v);
        MemAdr  = v.addr;
        tb_dout = v.data;
        tb_oe   = 1'b1;
        RamLB   = v.lb;
        RamUB   = v.ub;
        MemOE   = v.oe;
        MemWR   = 1'b0;
        RamCS   = 1'b0;
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d_wr_wait", idx), 16'(mem_wait), 16'(WRITE_LAT > 1));
        check($sformatf("v%0d_wr_bus", idx), MemDB, v.data);
        for (int k = 1; k < int'(v.ncyc); k++) @(posedge clk);
        #1;
        RamCS = 1'b1; MemWR = 1'b1; MemOE = 1'b1; RamLB = 1'b1; RamUB = 1'b1;
        tb_oe = 1'b0;
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d_abort", idx), 16'(wr_abort), 16'(v.abort));
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d_abort_clr", idx), 16'(wr_abort), 16'h0000);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input int idx, input logic [25:0] a, input logic [15:0] exp);
        MemAdr = a;
        tb_oe  = 1'b0;
        MemWR  = 1'b1;
        MemOE  = 1'b0;
        RamCS  = 1'b0;
        for (int k = 0; k < int'(READ_LAT); k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("v%0d_rd_wait%0d", idx, k), 16'(mem_wait), 16'h0001);
        end
        check_released($sformatf("v%0d_rd_early", idx));
        @(posedge clk); @(negedge clk);
        check($sformatf("v%0d_rd_wait_end", idx), 16'(mem_wait), 16'h0000);
        check($sformatf("v%0d_rd_data", idx), MemDB, exp);
        @(posedge clk); #1;
        RamCS = 1'b1; MemOE = 1'b1;
        @(posedge clk); #1;
        check_released($sformatf("v%0d_rd_release", idx));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded limit %0d", $time, 100000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back(wv(26'h005, 16'hBEEF, 1'b0, 1'b0, 1'b1, 3, 1'b0));
        vecs.push_back(rv(26'h005, 16'hBEEF));
        vecs.push_back(wv(26'h010, 16'hFFFF, 1'b0, 1'b0, 1'b1, 2, 1'b0));
        vecs.push_back(wv(26'h010, 16'h1234, 1'b0, 1'b1, 1'b1, 2, 1'b0));
        vecs.push_back(rv(26'h010, 16'hFF34));
        vecs.push_back(wv(26'h020, 16'h0F0F, 1'b0, 1'b0, 1'b1, 2, 1'b0));
        vecs.push_back(wv(26'h020, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1, 1'b1));
        vecs.push_back(rv(26'h020, 16'h0F0F));
        vecs.push_back(wv(26'h020, 16'h1111, 1'b1, 1'b1, 1'b1, 2, 1'b0));
        vecs.push_back(rv(26'h020, 16'h0F0F));
        vecs.push_back(wv(26'h030, 16'hAAAA, 1'b0, 1'b0, 1'b1, 2, 1'b0));
        vecs.push_back(wv(26'h030, 16'h5555, 1'b0, 1'b0, 1'b0, 2, 1'b0));
        vecs.push_back(rv(26'h030, 16'h5555));
        vecs.push_back(wv(26'h040, 16'h1357, 1'b0, 1'b0, 1'b1, 2, 1'b0));
        vecs.push_back(wv(26'h040, 16'hCAFE, 1'b1, 1'b0, 1'b1, 4, 1'b0));
        vecs.push_back(rv(26'h040, 16'hCA57));
        vecs.push_back(rv(26'h105, 16'hBEEF));
        vecs.push_back(wv(26'h20000FF, 16'h7E7E, 1'b0, 1'b0, 1'b1, 2, 1'b0));
        vecs.push_back(rv(26'h0FF, 16'h7E7E));
        vecs.push_back(wv(26'h050, 16'h4444, 1'b0, 1'b0, 1'b1, 2, 1'b0));

        // Idle bus, then an asynchronous reset assertion before any clock edge
        rst = 1'b1; MemAdv = 1'b1; MemClk = 1'b0;
        RamCS = 1'b1; MemOE = 1'b1; MemWR = 1'b1; RamLB = 1'b1; RamUB = 1'b1;
        MemAdr = '0; tb_oe = 1'b0; tb_dout = 16'h0000;
        #1 rst = 1'b0;
        #1;
        check("reset_wait", 16'(mem_wait), 16'h0000);
        check("reset_abort", 16'(wr_abort), 16'h0000);
        check_released("reset_bus");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_rd) do_read(i, vecs[i].addr, vecs[i].data);
            else               do_write(i, vecs[i]);
        end

        // Address change after one RD_DRIVE cycle restarts the read latency
        MemAdr = 26'h005; RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b1;
        repeat (READ_LAT + 1) @(posedge clk);
        @(negedge clk);
        check("chg_first_data", MemDB, 16'hBEEF);
        MemAdr = 26'h010;
        for (int k = 0; k < int'(READ_LAT); k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("chg_wait%0d", k), 16'(mem_wait), 16'h0001);
        end
        @(posedge clk); @(negedge clk);
        check("chg_wait_end", 16'(mem_wait), 16'h0000);
        check("chg_data", MemDB, 16'hFF34);
        @(posedge clk); #1;
        RamCS = 1'b1; MemOE = 1'b1;
        @(posedge clk); #1;
        check_released("chg_release");

        // Reset during RD_DRIVE through an aliased address releases the bus immediately
        MemAdr = 26'h105; RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b1;
        repeat (READ_LAT + 1) @(posedge clk);
        @(negedge clk);
        check("rstrd_data", MemDB, 16'hBEEF);
        #1 rst = 1'b0;
        #1;
        check("rstrd_wait", 16'(mem_wait), 16'h0000);
        check_released("rstrd_bus");
        RamCS = 1'b1; MemOE = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_read(100, 26'h005, 16'hBEEF);

        // Reset while holding a write must leave the old word in place
        MemAdr = 26'h050; tb_dout = 16'h9999; tb_oe = 1'b1;
        RamLB = 1'b0; RamUB = 1'b0; MemOE = 1'b1; MemWR = 1'b0; RamCS = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rstwr_hold_wait", 16'(mem_wait), 16'h0000);
        #1 rst = 1'b0;
        #1;
        RamCS = 1'b1; MemWR = 1'b1; RamLB = 1'b1; RamUB = 1'b1; tb_oe = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_read(101, 26'h050, 16'h4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cram_responder.md
CRAM_RESPONDER -- requirements
Module: cram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: number of word-address bits decoded; depth is 2^ADDR_BITS words of 16 bits.
REQ-002 SHALL have parameter READ_LAT, default 3: clk cycles from access start to valid read data (range 1-15).
REQ-003 SHALL have parameter WRITE_LAT, default 2: minimum clk cycles MemWR must stay low for a write to commit (range 1-15).
REQ-004 clk  input  1  sole clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 MemAdv  input  1  address-valid strobe, active-low; ignored (async mode only).
REQ-007 MemClk  input  1  memory burst clock; ignored (async mode only).
REQ-008 RamCS  input  1  chip select, active-low.
REQ-009 MemOE  input  1  output enable, active-low.
REQ-010 MemWR  input  1  write enable, active-low.
REQ-011 RamLB  input  1  lower byte enable (MemDB[7:0]), active-low.
REQ-012 RamUB  input  1  upper byte enable (MemDB[15:8]), active-low.
REQ-013 MemAdr  input  26 ([26:1])  word address; only MemAdr[ADDR_BITS:1] decoded, upper bits alias.
REQ-014 MemDB  inout  16  data bus; driven only in RD_DRIVE, otherwise high-Z.
REQ-015 mem_wait  output  1  high while an access is in RD_WAIT or WR_WAIT.
REQ-016 wr_abort  output  1  one-cycle pulse when a write ends before WRITE_LAT cycles.

Function
REQ-017 SHALL sample all bus inputs on the rising edge of clk; no combinational path from bus inputs to MemDB enable.
REQ-018 SHALL implement FSM states IDLE, RD_WAIT, RD_DRIVE, WR_WAIT, WR_HOLD.
REQ-019 IDLE: RamCS=0 & MemWR=0 -> WR_WAIT; RamCS=0 & MemOE=0 & MemWR=1 -> RD_WAIT; otherwise stay; write has priority when MemOE and MemWR are both low.
REQ-020 On leaving IDLE SHALL latch address, RamLB and RamUB and load a latency counter.
REQ-021 RD_WAIT: counter reaches READ_LAT -> RD_DRIVE; MemDB first driven exactly READ_LAT cycles after the start cycle.
REQ-022 RD_DRIVE: MemDB = stored word at latched address, full 16 bits regardless of byte enables.
REQ-023 In RD_WAIT or RD_DRIVE a change of decoded address SHALL re-latch it, return to RD_WAIT and restart the READ_LAT count.
REQ-024 In RD_WAIT/RD_DRIVE, RamCS=1 or MemOE=1 -> IDLE; MemDB high-Z from the next cycle.
REQ-025 In RD_WAIT/RD_DRIVE, MemWR=0 with RamCS=0 -> WR_WAIT (new write starts, drive released next cycle).
REQ-026 WR_WAIT: captures MemDB every cycle; counter reaches WRITE_LAT -> WR_HOLD.
REQ-027 WR_HOLD: captures MemDB every cycle; on MemWR=1 or RamCS=1 commits last captured data, lower byte if latched RamLB=0, upper byte if latched RamUB=0, then -> IDLE.
REQ-028 WR_WAIT ended by MemWR=1 or RamCS=1 SHALL discard the write, pulse wr_abort for one cycle, -> IDLE.
REQ-029 Both byte enables high on a committed write SHALL leave memory unchanged (not an abort).
REQ-030 Latency counters saturate; no wrap-around.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, MemDB high-Z, mem_wait=0, wr_abort=0, counters and latched address to 0.
REQ-032 Reset mid-write SHALL leave memory unchanged; array contents are not cleared by reset.
REQ-033 Exit from reset SHALL take effect on the first rising clk edge with rst=1.

Structure
REQ-034 State encoding and default latency constants SHALL live in the shared package cram_pkg.
REQ-035 Storage SHALL be one sub-module cram_array: 2^ADDR_BITS x 16, single port, per-byte write enable, asynchronous read.

Verification
REQ-036 Write 0xBEEF to addr 0x005, LB=UB=0, MemWR low 3 cycles -> read addr 0x005 returns 0xBEEF on MemDB exactly 3 cycles after start.
REQ-037 Write 0x1234 to 0x010 with UB=1, LB=0 over prior 0xFFFF -> read returns 0xFF34.
REQ-038 MemWR low 1 cycle (WRITE_LAT=2) with 0xAAAA to 0x020 -> wr_abort pulses once; read of 0x020 returns prior value.
REQ-039 Read 0x005 then change address to 0x010 after 1 cycle of RD_DRIVE -> mem_wait high 3 cycles, then MemDB=0xFF34.
REQ-040 MemOE and MemWR low together with 0x5555 to 0x030 -> treated as write, MemDB never driven; later read returns 0x5555.
REQ-041 Assert rst=0 during RD_DRIVE -> MemDB high-Z and mem_wait=0 without a clk edge; MemAdr 0x105 aliases 0x005 with ADDR_BITS=8.
